// File: rtl/data_memory_hs.sv
// data_memory_hs: request/response data memory for the MIPS datapath.
// One access outstanding at a time: IDLE accepts, BUSY counts down the wait
// states and executes, DONE pulses o_done for a single cycle.
//
// state  | meaning
// S_IDLE | ready for a request, o_ready=1
// S_BUSY | captured access waiting on the wait counter, executes at count 0
// S_DONE | one-cycle completion pulse, o_rdata/o_err valid
module data_memory_hs #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2,
  parameter int INIT_BASE   = 1000,
  parameter int INIT_COUNT  = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic                o_ready,
  output logic                o_done,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Power-up image: all zero except the preloaded test array.
  function automatic mem_t f_init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int k = 0; k < INIT_COUNT; k++)
      if (INIT_BASE + k < DEPTH) m[INIT_BASE + k] = DATA_W'(10 * (k + 1));
    return m;
  endfunction

  // Contents are set only at power-up and by writes; reset leaves them alone.
  mem_t r_mem = f_init_mem();

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [ADDR_W-3:0] w_widx;
  logic [IDX_W-1:0]  w_mem_idx;
  logic              w_legal;
  logic              w_exec;

  assign w_widx    = r_addr[ADDR_W-1:2];
  assign w_mem_idx = w_widx[IDX_W-1:0];
  assign w_legal   = (r_addr[1:0] == 2'b00) && (w_widx < DEPTH_LIM);
  assign w_exec    = (r_state == S_BUSY) && (r_cnt == 4'd0);

  assign o_ready = (r_state == S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

  // Handshake FSM, request capture, wait counter and registered read result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_be    <= i_be;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_DONE;
            if (!w_legal) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end else begin
              r_err <= 1'b0;
              // a write leaves the last read result in place
              if (!r_we) r_rdata <= r_mem[w_mem_idx];
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-enabled write port. A reset during BUSY forces IDLE, so the
  // pending write can never reach this block.
  always_ff @(posedge i_clk) begin
    if (w_exec && w_legal && r_we) begin
      for (int i = 0; i < NB; i++)
        if (r_be[i]) r_mem[w_mem_idx][8*i +: 8] <= r_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: a table of accesses checked through a scoreboard
// on the default build, a back-to-back handshake run with zero wait states,
// a reset during a pending write, and a wide 16-word write/read sweep.
module tb_data_memory_hs;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: default parameters (WAIT_CYCLES=2)
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic        m_ready, m_done, m_err;
  logic [31:0] m_rdata;

  data_memory_hs u_main (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(m_req), .i_we(m_we), .i_addr(m_addr),
    .i_wdata(m_wdata), .i_be(m_be), .o_ready(m_ready), .o_done(m_done),
    .o_rdata(m_rdata), .o_err(m_err));

  // handshake instance: no wait states
  logic        h_req = 1'b0;
  logic [31:0] h_addr = '0;
  logic        h_ready, h_done, h_err;
  logic [31:0] h_rdata;

  data_memory_hs #(.WAIT_CYCLES(0)) u_hs (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(h_req), .i_we(1'b0), .i_addr(h_addr),
    .i_wdata(32'h0), .i_be(4'hF), .o_ready(h_ready), .o_done(h_done),
    .o_rdata(h_rdata), .o_err(h_err));

  // sweep instance: 64-bit, 16 words, 15 wait states, no preload
  logic        s_req = 1'b0, s_we = 1'b0;
  logic [31:0] s_addr = '0;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_be = '0;
  logic        s_ready, s_done, s_err;
  logic [63:0] s_rdata;

  data_memory_hs #(.DATA_W(64), .DEPTH(16), .WAIT_CYCLES(15), .INIT_BASE(0),
                   .INIT_COUNT(0)) u_sw (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(s_req), .i_we(s_we), .i_addr(s_addr),
    .i_wdata(s_wdata), .i_be(s_be), .o_ready(s_ready), .o_done(s_done),
    .o_rdata(s_rdata), .o_err(s_err));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          idx;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every completion of the main instance pops one expectation
  always @(negedge clk) begin
    if (rst_n && m_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(m_done), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("v%0d_rdata", mon_e.idx), 64'(m_rdata), 64'(mon_e.rdata));
        check($sformatf("v%0d_err", mon_e.idx), 64'(m_err), 64'(mon_e.err));
        check($sformatf("v%0d_latency", mon_e.idx), 64'(cyc - mon_e.acc_cyc), 64'd3);
      end
    end
  end

  // issue one access on the main instance; starts and ends near a negedge
  task automatic m_access(input vec_t v, input int idx);
    exp_t e;
    int n;
    n = 0;
    while (!m_ready && n < 50) begin @(negedge clk); n++; end
    if (!m_ready) check($sformatf("v%0d_ready_timeout", idx), 64'(m_ready), 64'd1);
    m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wdata = v.wdata; m_be = v.be;
    @(posedge clk); #1;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.acc_cyc = cyc; e.idx = idx;
    sb_q.push_back(e);
    m_req = 1'b0;
    m_addr = 32'hFFFF_FFFF;  // must not matter once captured
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin @(negedge clk); #1; n++; end
    if (sb_q.size() != 0) begin
      check($sformatf("v%0d_done_timeout", idx), 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic s_access(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat);
    int n, t;
    n = 0;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = wd; s_be = 8'hFF;
    @(posedge clk); #1;
    t = cyc;
    s_req = 1'b0;
    n = 0;
    while (!s_done && n < 40) begin @(negedge clk); n++; end
    rd = s_rdata; er = s_err;
    lat = s_done ? (cyc - t) : -1;
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat[16];
    logic [63:0] rd;
    logic        er;
    int          lat, t, t_prev, n;

    //           we   addr   wdata          be    err  rdata
    vecs[0]  = '{1'b0, 4000,  32'h0,        4'hF, 1'b0, 32'd10};
    vecs[1]  = '{1'b0, 4036,  32'h0,        4'hF, 1'b0, 32'd100};
    vecs[2]  = '{1'b1, 4004,  32'hAABBCCDD, 4'h2, 1'b0, 32'd100};
    vecs[3]  = '{1'b0, 4004,  32'h0,        4'h0, 1'b0, 32'h0000CC14};
    vecs[4]  = '{1'b1, 4004,  32'hAABBCCDD, 4'hF, 1'b0, 32'h0000CC14};
    vecs[5]  = '{1'b0, 4004,  32'h0,        4'h1, 1'b0, 32'hAABBCCDD};
    vecs[6]  = '{1'b0, 16384, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 4002,  32'h12345678, 4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 4000,  32'h0,        4'hF, 1'b0, 32'd10};
    vecs[9]  = '{1'b1, 4000,  32'hFFFFFFFF, 4'h0, 1'b0, 32'd10};
    vecs[10] = '{1'b0, 4000,  32'h0,        4'hF, 1'b0, 32'd10};
    vecs[11] = '{1'b0, 4001,  32'h0,        4'hF, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 16380, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 16380, 32'h13572468, 4'hC, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 16380, 32'h0,        4'hF, 1'b0, 32'h13570000};
    vecs[15] = '{1'b0, 4036,  32'h0,        4'hF, 1'b0, 32'd100};

    // reset
    #2 rst_n = 1'b0;
    m_req = 1'b1;  // ignored while in reset
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(m_ready), 64'd1);
    check("rst_done",  64'(m_done),  64'd0);
    check("rst_err",   64'(m_err),   64'd0);
    check("rst_rdata", 64'(m_rdata), 64'd0);
    m_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven accesses on the main instance
    for (int i = 0; i < 16; i++) m_access(vecs[i], i);

    // reset while a write is pending
    m_req = 1'b1; m_we = 1'b1; m_addr = 4008; m_wdata = 32'hDEADBEEF; m_be = 4'hF;
    @(posedge clk); #1;
    m_req = 1'b0;
    @(negedge clk);
    check("mid_busy_before_rst", 64'(m_ready), 64'd0);
    rst_n = 1'b0;
    m_req = 1'b1;
    #1;
    check("mid_rst_ready", 64'(m_ready), 64'd1);
    check("mid_rst_done",  64'(m_done),  64'd0);
    check("mid_rst_rdata", 64'(m_rdata), 64'd0);
    check("mid_rst_err",   64'(m_err),   64'd0);
    @(posedge clk); #1;
    check("mid_rst_req_ignored", 64'(m_ready), 64'd1);
    @(negedge clk);
    m_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    m_access('{1'b0, 4008, 32'h0, 4'hF, 1'b0, 32'd30}, 100);

    // back-to-back requests with req held high, zero wait states
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!h_ready && n < 20) begin @(negedge clk); n++; end
      h_req = 1'b1;
      h_addr = 32'(4000 + 4 * k);
      @(posedge clk); #1;
      t = cyc;
      if (k > 0) check($sformatf("hs%0d_accept_gap", k), 64'(t - t_prev), 64'd3);
      t_prev = t;
      h_addr = 32'd16384;  // changed while BUSY, must not affect the result
      n = 0;
      while (!h_done && n < 20) begin @(negedge clk); n++; end
      check($sformatf("hs%0d_latency", k), 64'(cyc - t), 64'd1);
      check($sformatf("hs%0d_rdata", k), 64'(h_rdata), 64'(10 * (k + 1)));
      check($sformatf("hs%0d_err", k), 64'(h_err), 64'd0);
      @(negedge clk);
    end
    h_req = 1'b0;

    // wide sweep: write all 16 words, then read them back
    for (int i = 0; i < 16; i++) pat[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) begin
      s_access(1'b1, 32'(i * 4), pat[i], rd, er, lat);
      check($sformatf("sw_w%0d_err", i), 64'(er), 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      s_access(1'b0, 32'(i * 4), 64'h0, rd, er, lat);
      check($sformatf("sw_r%0d_rdata", i), rd, pat[i]);
      check($sformatf("sw_r%0d_err", i), 64'(er), 64'd0);
      check($sformatf("sw_r%0d_latency", i), 64'(lat), 64'd16);
    end
    s_access(1'b0, 32'd64, 64'h0, rd, er, lat);
    check("sw_oob_err", 64'(er), 64'd1);
    check("sw_oob_rdata", rd, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
